// File: rtl/fpu_pkg.sv
// Shared definitions for the fixed-point unit: default Q-format sizes,
// the multiply sequencer state encoding and the FPU operation codes.
package fpu_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_FBITS = 10;
    localparam int MUL_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PP0,
        ST_PP1,
        ST_PP2,
        ST_PP3,
        ST_DONE
    } mul_state_e;

    typedef enum logic [1:0] {
        FPU_OP_ADD,
        FPU_OP_SUB,
        FPU_OP_MUL,
        FPU_OP_DIV
    } fpu_op_e;

endpackage

// File: rtl/mul_16x16.sv
// Unsigned 16x16 combinational multiplier shared by the partial-product steps.
module mul_16x16
    import fpu_pkg::*;
(
    input  logic [MUL_W-1:0]   a,
    input  logic [MUL_W-1:0]   b,
    output logic [2*MUL_W-1:0] p
);

    assign p = (2*MUL_W)'(a) * (2*MUL_W)'(b);

endmodule

// File: rtl/fixed_point_mul_sequencer.sv
// Unsigned fixed-point multiplier: four partial products through one 16x16 multiplier.
// Build option FPMUL_SATURATE_EN: result saturates to all ones on overflow. WIDTH must be <= 32.
module fixed_point_mul_sequencer
    import fpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int FBITS = DEFAULT_FBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   operand_1,
    input  logic [WIDTH-1:0]   operand_2,
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   result,
    output logic               overflow
);

    localparam int OPW = 2 * MUL_W;
    localparam int ACW = 2 * OPW;

    mul_state_e         state, state_nxt;
    logic [OPW-1:0]     op_a, op_b;
    logic [ACW-1:0]     acc;
    logic [MUL_W-1:0]   mul_a, mul_b;
    logic [OPW-1:0]     mul_p;
    logic [ACW-1:0]     term;
    logic [5:0]         term_shift;
    logic               accept;
    logic               acc_ovf;
    logic [WIDTH-1:0]   acc_result;

    assign accept = start && (state == ST_IDLE || state == ST_DONE);
    assign busy   = (state == ST_PP0) || (state == ST_PP1) ||
                    (state == ST_PP2) || (state == ST_PP3);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_PP0;
            ST_PP0:  state_nxt = ST_PP1;
            ST_PP1:  state_nxt = ST_PP2;
            ST_PP2:  state_nxt = ST_PP3;
            ST_PP3:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = start ? ST_PP0 : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand halves and weight of the partial product handled this cycle.
    always_comb begin
        mul_a      = '0;
        mul_b      = '0;
        term_shift = '0;
        case (state)
            ST_PP0: begin
                mul_a = op_a[MUL_W-1:0];
                mul_b = op_b[MUL_W-1:0];
            end
            ST_PP1: begin
                mul_a      = op_a[OPW-1:MUL_W];
                mul_b      = op_b[MUL_W-1:0];
                term_shift = 6'd16;
            end
            ST_PP2: begin
                mul_a      = op_a[MUL_W-1:0];
                mul_b      = op_b[OPW-1:MUL_W];
                term_shift = 6'd16;
            end
            ST_PP3: begin
                mul_a      = op_a[OPW-1:MUL_W];
                mul_b      = op_b[OPW-1:MUL_W];
                term_shift = 6'd32;
            end
            default: ;
        endcase
    end

    mul_16x16 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    assign term    = ACW'(mul_p) << term_shift;
    assign acc_ovf = |acc[2*WIDTH-1:WIDTH+FBITS];

`ifdef FPMUL_SATURATE_EN
    assign acc_result = acc_ovf ? {WIDTH{1'b1}} : acc[WIDTH+FBITS-1:FBITS];
`else
    assign acc_result = acc[WIDTH+FBITS-1:FBITS];
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operands are captured only on an accepted start; later input changes are invisible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a <= '0;
            op_b <= '0;
            acc  <= '0;
        end else if (accept) begin
            op_a <= OPW'(operand_1);
            op_b <= OPW'(operand_2);
            acc  <= '0;
        end else if (busy) begin
            acc  <= acc + term;
        end
    end

    // Outputs are registered while leaving DONE, so ready lands five edges after acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready    <= 1'b0;
            product  <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            ready <= (state == ST_DONE);
            if (state == ST_DONE) begin
                product  <= acc[2*WIDTH-1:0];
                result   <= acc_result;
                overflow <= acc_ovf;
            end
        end
    end

endmodule
